// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Load-use / RAW hazard controller for a 5-stage pipeline.
//                Keeps a 3-entry destination scoreboard (EX, MEM, WR) that
//                shadows the downstream stage registers. When an ID-stage
//                source matches a pending destination, the front end stalls
//                and a bubble goes into ID/EX until the producer has left the
//                WR stage. A saturating counter records stalled cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_regwr,
    input  logic [4:0]       id_aw,
    input  logic             flush,
    output logic             stall,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             in_stall
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [4:0]       C_REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Scoreboard entries: valid bit plus destination register.
    logic       r_ex_v;
    logic [4:0] r_ex_dst;
    logic       r_mem_v;
    logic [4:0] r_mem_dst;
    logic       r_wr_v;
    logic [4:0] r_wr_dst;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [CNT_W-1:0] r_stall_cnt;

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_hazard;
    logic w_ex_load_v;

    // Source-vs-scoreboard match; $0 is never a real dependency.
    always_comb begin
        w_rs_hit = 1'b0;
        w_rt_hit = 1'b0;
        if (id_rs != C_REG_ZERO) begin
            w_rs_hit = (r_ex_v  && (r_ex_dst  == id_rs)) ||
                       (r_mem_v && (r_mem_dst == id_rs)) ||
                       (r_wr_v  && (r_wr_dst  == id_rs));
        end
        if (id_rt != C_REG_ZERO) begin
            w_rt_hit = (r_ex_v  && (r_ex_dst  == id_rt)) ||
                       (r_mem_v && (r_mem_dst == id_rt)) ||
                       (r_wr_v  && (r_wr_dst  == id_rt));
        end
    end

    // Hazard decision: reset and flush both override any pending match.
    always_comb begin
        w_hazard = ~rst & id_valid & ~flush & (w_rs_hit | (id_uses_rt & w_rt_hit));
    end

    assign stall  = w_hazard;
    assign bubble = w_hazard;

    // Only an instruction that actually advances into EX and writes a
    // nonzero register becomes a pending producer.
    always_comb begin
        w_ex_load_v = id_valid & id_regwr & ~flush & ~w_hazard & (id_aw != C_REG_ZERO);
    end

    // Scoreboard shift: EX takes the ID result, MEM and WR follow unconditionally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_v    <= 1'b0;
            r_ex_dst  <= C_REG_ZERO;
            r_mem_v   <= 1'b0;
            r_mem_dst <= C_REG_ZERO;
            r_wr_v    <= 1'b0;
            r_wr_dst  <= C_REG_ZERO;
        end else begin
            r_ex_v    <= w_ex_load_v;
            r_ex_dst  <= id_aw;
            r_mem_v   <= r_ex_v;
            r_mem_dst <= r_ex_dst;
            r_wr_v    <= r_mem_v;
            r_wr_dst  <= r_mem_dst;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: enter/hold STALL while a hazard is present; flush wins.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_hazard) begin
                    w_state_nxt = ST_STALL;
                end
            end
            ST_STALL: begin
                if (!w_hazard) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
        if (flush) begin
            w_state_nxt = ST_RUN;
        end
    end

    assign in_stall = (r_state == ST_STALL);

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && (r_stall_cnt != C_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. Directed vector table,
//                hand-written saturation sequence, and randomized traffic
//                compared against a register-ready-time reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_regwr;
    logic [4:0]       id_aw;
    logic             flush;
    logic             stall;
    logic             bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic             in_stall;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .id_regwr   (id_regwr),
        .id_aw      (id_aw),
        .flush      (flush),
        .stall      (stall),
        .bubble     (bubble),
        .stall_cnt  (stall_cnt),
        .in_stall   (in_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: each register carries the cycle number from which
    // a reader may use it without waiting. A producer issued at cycle t
    // occupies EX, MEM and WR during t+1..t+3, so it is readable at t+4.
    longint m_ready[32];
    longint m_t;
    int     m_cnt;
    logic   m_prev_stall;

    typedef struct {
        logic       r;
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       u;
        logic       w;
        logic [4:0] aw;
        logic       f;
        logic       e_stall;
        logic       e_in;
        int         e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic v, logic [4:0] rs, logic [4:0] rt,
                                logic u, logic w, logic [4:0] aw, logic f,
                                logic es, logic ei, int ec);
        vec_t x;
        x.r = r; x.v = v; x.rs = rs; x.rt = rt; x.u = u; x.w = w;
        x.aw = aw; x.f = f; x.e_stall = es; x.e_in = ei; x.e_cnt = ec;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, m_t);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_ready[i] = 0;
        m_cnt        = 0;
        m_prev_stall = 1'b0;
    endtask

    // One cycle: drive inputs, sample at the falling edge, check against
    // the model, advance the model across the rising edge.
    task automatic step(input logic r, input logic v, input logic [4:0] rs,
                        input logic [4:0] rt, input logic u, input logic w,
                        input logic [4:0] aw, input logic f,
                        output logic o_stall, output logic o_in, output int o_cnt);
        logic exp_stall;
        bit   rs_wait;
        bit   rt_wait;
        rst = r; id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = u;
        id_regwr = w; id_aw = aw; flush = f;
        @(negedge clk);
        rs_wait   = (rs != 0) && (m_ready[rs] > m_t);
        rt_wait   = (rt != 0) && (m_ready[rt] > m_t);
        exp_stall = !r && v && !f && (rs_wait || (u && rt_wait));
        chk("stall",     stall,     exp_stall);
        chk("bubble",    bubble,    exp_stall);
        chk("in_stall",  in_stall,  m_prev_stall);
        chk("stall_cnt", stall_cnt, m_cnt);
        o_stall = stall;
        o_in    = in_stall;
        o_cnt   = int'(stall_cnt);
        if (r) begin
            model_reset();
        end else begin
            if (v && w && !f && !exp_stall && aw != 0) m_ready[aw] = m_t + 4;
            if (exp_stall && m_cnt < CNT_MAX) m_cnt++;
            m_prev_stall = exp_stall;
        end
        m_t++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic s_o;
        logic i_o;
        int   c_o;

        rst = 1'b1; id_valid = 1'b0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        id_regwr = 0; id_aw = 0; flush = 0;
        m_t = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        //             r  v  rs rt u  w  aw f   stall in cnt
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0));  // reset state
        // back-to-back dependency on $3
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 3, 0,  0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0,  1, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0,  1, 1, 1));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0,  1, 1, 2));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0,  0, 1, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 3));
        // distance-2 on $5 via rt, rt used
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 5, 0,  0, 0, 3));
        tbl.push_back(mk(0, 1, 1, 2, 1, 0, 0, 0,  0, 0, 3));
        tbl.push_back(mk(0, 1, 0, 5, 1, 0, 0, 0,  1, 0, 3));
        tbl.push_back(mk(0, 1, 0, 5, 1, 0, 0, 0,  1, 1, 4));
        tbl.push_back(mk(0, 1, 0, 5, 1, 0, 0, 0,  0, 1, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 5));
        // distance-2 on $5, rt not used
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 5, 0,  0, 0, 5));
        tbl.push_back(mk(0, 1, 1, 2, 1, 0, 0, 0,  0, 0, 5));
        tbl.push_back(mk(0, 1, 0, 5, 0, 0, 0, 0,  0, 0, 5));
        // $0 immunity
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0,  0, 0, 5));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0,  0, 0, 5));
        // flush during hazard; squashed writer of $9
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 7, 0,  0, 0, 5));
        tbl.push_back(mk(0, 1, 7, 0, 0, 1, 9, 1,  0, 0, 5));
        tbl.push_back(mk(0, 1, 1, 2, 1, 0, 0, 0,  0, 0, 5));
        tbl.push_back(mk(0, 1, 9, 9, 1, 0, 0, 0,  0, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 5));
        // reset in the second stall cycle
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 3, 0,  0, 0, 5));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0,  1, 0, 5));
        tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0,  0, 1, 6));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 3, 1, 0, 0, 0,  0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].u, tbl[i].w,
                 tbl[i].aw, tbl[i].f, s_o, i_o, c_o);
            chk($sformatf("tbl%0d.stall", i), s_o, tbl[i].e_stall);
            chk($sformatf("tbl%0d.in_stall", i), i_o, tbl[i].e_in);
            chk($sformatf("tbl%0d.cnt", i), c_o, tbl[i].e_cnt);
        end

        // Saturation: a $4 -> $4 dependency chain yields 3 stalls per link.
        for (int i = 0; i < 32; i++) begin
            step(0, 1, 4, 0, 0, 1, 4, 0, s_o, i_o, c_o);
        end
        chk("sat.cnt", c_o, CNT_MAX);
        step(0, 1, 4, 0, 0, 1, 4, 0, s_o, i_o, c_o);
        step(0, 1, 4, 0, 0, 1, 4, 0, s_o, i_o, c_o);
        chk("sat.hold", c_o, CNT_MAX);

        // Randomized traffic over a small register window.
        step(1, 0, 0, 0, 0, 0, 0, 0, s_o, i_o, c_o);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 4) != 0),
                 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 7) == 0),
                 s_o, i_o, c_o);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
